fu_issue_fifo: RTL and testbench

Per-functional-unit issue buffer on the consumer side of the reservation-station issue interface. Each instance snoops the RS's 3-wide issue bundle, captures the packets whose FU selector matches its class, and queues them in age order. It presents them one at a time, first-word-fall-through, to its functional unit. It returns a registered stall bit; the top level packs these bits into the FU_FIFO_PACKET that the RS uses to throttle issue.

---
 rtl/fu_issue_fifo_pkg.sv | 46 ++++
 rtl/fu_issue_fifo_if.sv | 28 ++
 rtl/issue_lane_compact.sv | 24 ++
 rtl/fu_issue_fifo.sv | 117 +++++++++++
 tb/tb_fu_issue_fifo.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/fu_issue_fifo_pkg.sv
// Shared issue-side types: RS issue packet, FU class select, per-FU stall packet.
// Also holds the issue width and FU buffer depth defaults.
package fu_issue_fifo_pkg;

    localparam int unsigned ISSUE_WIDTH   = 3;
    localparam int unsigned FU_FIFO_DEPTH = 8;
    localparam int unsigned PR_W          = 6;
    localparam int unsigned ROB_W         = 5;

    typedef enum logic [2:0] {
        ALU_1    = 3'd0,
        ALU_2    = 3'd1,
        ALU_3    = 3'd2,
        MULT_1   = 3'd3,
        MULT_2   = 3'd4,
        LOAD_1   = 3'd5,
        STORE_1  = 3'd6,
        BRANCH_1 = 3'd7
    } fu_select_e;

    typedef struct packed {
        logic             valid;
        fu_select_e       dec_fu_unit_sel;
        logic [PR_W-1:0]  src1_pr;
        logic [PR_W-1:0]  src2_pr;
        logic [PR_W-1:0]  dest_pr;
        logic [ROB_W-1:0] rob_tag;
    } rs_s_packet_t;

    // One stall bit per FU buffer, packed by the top level for the RS
    typedef struct packed {
        logic alu_1;
        logic alu_2;
        logic alu_3;
        logic mult_1;
        logic mult_2;
        logic load_1;
        logic store_1;
        logic branch_1;
    } fu_fifo_packet_t;

    function automatic logic lane_matches(input rs_s_packet_t pkt, input fu_select_e sel);
        return pkt.valid && (pkt.dec_fu_unit_sel == sel);
    endfunction

endpackage

// File: rtl/fu_issue_fifo_if.sv
// Issue-bundle / FU-side handshake bundle for one FU issue buffer.
interface fu_issue_fifo_if
    import fu_issue_fifo_pkg::*;
#(
    parameter int unsigned DEPTH   = FU_FIFO_DEPTH,
    parameter int unsigned ISSUE_W = ISSUE_WIDTH
);

    rs_s_packet_t [ISSUE_W-1:0]   rsb_issue_packets;
    logic                         squash;
    logic                         fu_ready;
    rs_s_packet_t                 fu_pkt;
    logic                         fu_valid;
    logic                         fifo_stall;
    logic [$clog2(DEPTH):0]       count;
    logic                         overflow_err;

    modport master (
        output rsb_issue_packets, squash, fu_ready,
        input  fu_pkt, fu_valid, fifo_stall, count, overflow_err
    );

    modport slave (
        input  rsb_issue_packets, squash, fu_ready,
        output fu_pkt, fu_valid, fifo_stall, count, overflow_err
    );

endinterface

// File: rtl/issue_lane_compact.sv
// Combinational lane compactor: per-lane write offset (exclusive prefix popcount)
// and total number of matching lanes.
module issue_lane_compact #(
    parameter int unsigned ISSUE_W = 3,
    parameter int unsigned OFF_W   = $clog2(ISSUE_W + 1)
) (
    input  logic [ISSUE_W-1:0]            lane_match,
    output logic [ISSUE_W-1:0][OFF_W-1:0] lane_off,
    output logic [OFF_W-1:0]              n_wr
);

    logic [OFF_W-1:0] acc;

    always_comb begin
        acc      = '0;
        lane_off = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            lane_off[i] = acc;
            acc         = acc + OFF_W'(lane_match[i]);
        end
        n_wr = acc;
    end

endmodule

// File: rtl/fu_issue_fifo.sv
// Per-FU issue buffer: captures matching lanes of the RS issue bundle in age
// order and presents them first-word-fall-through to the functional unit.
module fu_issue_fifo
    import fu_issue_fifo_pkg::*;
#(
    parameter fu_select_e  FU_SEL  = ALU_1,
    parameter int unsigned DEPTH   = FU_FIFO_DEPTH,
    parameter int unsigned ISSUE_W = ISSUE_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    fu_issue_fifo_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OFF_W = $clog2(ISSUE_W + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [ISSUE_W-1:0]            lane_match;
    logic [ISSUE_W-1:0][OFF_W-1:0] lane_off;
    logic [OFF_W-1:0]              n_wr;

    rs_s_packet_t     mem_q [DEPTH];
    rs_s_packet_t     mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             stall_q, stall_d;
    logic             ovf_q, ovf_d;

    logic             pop;
    logic             wr_ok;
    logic [SUM_W-1:0] occ_after;

    always_comb begin
        lane_match = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            lane_match[i] = lane_matches(bus.rsb_issue_packets[i], FU_SEL);
        end
    end

    issue_lane_compact #(
        .ISSUE_W (ISSUE_W),
        .OFF_W   (OFF_W)
    ) u_compact (
        .lane_match (lane_match),
        .lane_off   (lane_off),
        .n_wr       (n_wr)
    );

    // A same-cycle pop frees a slot before the capacity check; all-or-nothing write
    always_comb begin
        pop       = (count_q != '0) && bus.fu_ready;
        occ_after = SUM_W'(count_q) - SUM_W'(pop) + SUM_W'(n_wr);
        wr_ok     = (occ_after <= SUM_W'(DEPTH));

        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (bus.squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (wr_ok) begin
                for (int i = 0; i < ISSUE_W; i++) begin
                    if (lane_match[i]) begin
                        mem_d[tail_q + PTR_W'(lane_off[i])] = bus.rsb_issue_packets[i];
                    end
                end
                tail_d  = tail_q + PTR_W'(n_wr);
                count_d = count_q - CNT_W'(pop) + CNT_W'(n_wr);
            end else begin
                count_d = count_q - CNT_W'(pop);
                ovf_d   = 1'b1;
            end
        end

        // Headroom of ISSUE_W covers the one-cycle lag seen by the RS
        stall_d = (count_d > CNT_W'(DEPTH - ISSUE_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            stall_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            stall_q <= stall_d;
            ovf_q   <= ovf_d;
        end
    end

    // Entry storage needs no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.fu_pkt       = mem_q[head_q];
    assign bus.fu_valid     = (count_q != '0);
    assign bus.count        = count_q;
    assign bus.fifo_stall   = stall_q;
    assign bus.overflow_err = ovf_q;

endmodule

// File: tb/tb_fu_issue_fifo.sv
// Directed vector bench for fu_issue_fifo (ALU_1 instance, DEPTH 8, 3 lanes).
module tb_fu_issue_fifo;
    import fu_issue_fifo_pkg::*;

    typedef struct {
        logic       rst_i;
        logic       sq;
        logic       rdy;
        logic [2:0] lv;
        logic [2:0] lmul;
        logic [5:0] t0;
        logic [5:0] t1;
        logic [5:0] t2;
        logic [3:0] e_cnt;
        logic       e_val;
        logic [5:0] e_head;
        logic       e_stall;
        logic       e_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    fu_issue_fifo_if #(.DEPTH(8), .ISSUE_W(3)) bus();

    fu_issue_fifo #(
        .FU_SEL  (ALU_1),
        .DEPTH   (8),
        .ISSUE_W (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic rs_s_packet_t mk_pkt(input logic vld, input fu_select_e sel, input logic [5:0] tag);
        rs_s_packet_t p;
        p.valid           = vld;
        p.dec_fu_unit_sel = sel;
        p.src1_pr         = tag;
        p.src2_pr         = tag + 6'd1;
        p.dest_pr         = tag ^ 6'h2A;
        p.rob_tag         = tag[4:0];
        return p;
    endfunction

    function automatic vec_t v(input logic r, input logic sq, input logic rdy,
                               input logic [2:0] lv, input logic [2:0] lmul,
                               input logic [5:0] t0, input logic [5:0] t1, input logic [5:0] t2,
                               input logic [3:0] cnt, input logic val, input logic [5:0] head,
                               input logic stall, input logic ovf);
        vec_t x;
        x.rst_i = r;   x.sq = sq;     x.rdy = rdy;
        x.lv = lv;     x.lmul = lmul;
        x.t0 = t0;     x.t1 = t1;     x.t2 = t2;
        x.e_cnt = cnt; x.e_val = val; x.e_head = head;
        x.e_stall = stall; x.e_ovf = ovf;
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic sq, input logic rdy,
                         input logic [2:0] lv, input logic [2:0] lmul,
                         input logic [5:0] t0, input logic [5:0] t1, input logic [5:0] t2);
        logic [5:0] tags [3];
        tags[0] = t0; tags[1] = t1; tags[2] = t2;
        rst          = r;
        bus.squash   = sq;
        bus.fu_ready = rdy;
        for (int i = 0; i < 3; i++) begin
            bus.rsb_issue_packets[i] = mk_pkt(lv[i], lmul[i] ? MULT_1 : ALU_1, tags[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [3:0] cnt, input logic val,
                               input logic [5:0] head, input logic stall, input logic ovf);
        check({tag, ".count"}, 64'(bus.count), 64'(cnt));
        check({tag, ".valid"}, 64'(bus.fu_valid), 64'(val));
        check({tag, ".stall"}, 64'(bus.fifo_stall), 64'(stall));
        check({tag, ".ovf"},   64'(bus.overflow_err), 64'(ovf));
        if (val) check({tag, ".head"}, 64'(bus.fu_pkt), 64'(mk_pkt(1'b1, ALU_1, head)));
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 6'd0, 6'd0, 6'd0);

        //         rst sq rdy lv      lmul    t0  t1  t2   cnt val head stl ovf
        vecs.push_back(v(1, 0, 0, 3'b000, 3'b000,  0,  0,  0,   0, 0,  0, 0, 0));
        vecs.push_back(v(0, 0, 0, 3'b111, 3'b010,  1,  3,  7,   2, 1,  1, 0, 0));
        vecs.push_back(v(0, 0, 1, 3'b000, 3'b000,  0,  0,  0,   1, 1,  7, 0, 0));
        vecs.push_back(v(0, 0, 1, 3'b000, 3'b000,  0,  0,  0,   0, 0,  0, 0, 0));
        vecs.push_back(v(0, 0, 0, 3'b111, 3'b000, 10, 11, 12,   3, 1, 10, 0, 0));
        vecs.push_back(v(0, 0, 0, 3'b111, 3'b000, 13, 14, 15,   6, 1, 10, 1, 0));
        vecs.push_back(v(0, 0, 1, 3'b000, 3'b000,  0,  0,  0,   5, 1, 11, 0, 0));
        vecs.push_back(v(0, 0, 0, 3'b111, 3'b000, 16, 17, 18,   8, 1, 11, 1, 0));
        vecs.push_back(v(0, 0, 1, 3'b001, 3'b000, 20,  0,  0,   8, 1, 12, 1, 0));
        vecs.push_back(v(0, 0, 1, 3'b011, 3'b000, 21, 22,  0,   7, 1, 13, 1, 1));
        vecs.push_back(v(0, 0, 1, 3'b000, 3'b000,  0,  0,  0,   6, 1, 14, 1, 1));
        vecs.push_back(v(0, 0, 1, 3'b000, 3'b000,  0,  0,  0,   5, 1, 15, 0, 1));
        vecs.push_back(v(0, 0, 1, 3'b000, 3'b000,  0,  0,  0,   4, 1, 16, 0, 1));
        vecs.push_back(v(0, 0, 1, 3'b000, 3'b000,  0,  0,  0,   3, 1, 17, 0, 1));
        vecs.push_back(v(0, 0, 1, 3'b000, 3'b000,  0,  0,  0,   2, 1, 18, 0, 1));
        vecs.push_back(v(0, 0, 1, 3'b000, 3'b000,  0,  0,  0,   1, 1, 20, 0, 1));
        vecs.push_back(v(0, 0, 0, 3'b111, 3'b000, 23, 24, 25,   4, 1, 20, 0, 1));
        vecs.push_back(v(0, 1, 1, 3'b111, 3'b000, 30, 31, 32,   0, 0,  0, 0, 1));
        vecs.push_back(v(0, 0, 0, 3'b011, 3'b001, 40, 33, 41,   1, 1, 33, 0, 1));
        vecs.push_back(v(0, 0, 1, 3'b000, 3'b000,  0,  0,  0,   0, 0,  0, 0, 1));
        vecs.push_back(v(0, 0, 0, 3'b111, 3'b111, 42, 43, 44,   0, 0,  0, 0, 1));

        foreach (vecs[i]) begin
            drive(vecs[i].rst_i, vecs[i].sq, vecs[i].rdy, vecs[i].lv, vecs[i].lmul,
                  vecs[i].t0, vecs[i].t1, vecs[i].t2);
            step();
            check_state($sformatf("v%0d", i), vecs[i].e_cnt, vecs[i].e_val,
                        vecs[i].e_head, vecs[i].e_stall, vecs[i].e_ovf);
        end

        // Streaming push-1/pop-1 across several pointer wraps
        drive(1'b0, 1'b0, 1'b0, 3'b001, 3'b000, 6'd0, 6'd0, 6'd0);
        step();
        check("wrap.count0", 64'(bus.count), 64'(1));
        for (int k = 1; k < 20; k++) begin
            check($sformatf("wrap.head%0d", k - 1), 64'(bus.fu_pkt), 64'(mk_pkt(1'b1, ALU_1, 6'(k - 1))));
            drive(1'b0, 1'b0, 1'b1, 3'b001, 3'b000, 6'(k), 6'd0, 6'd0);
            step();
            check($sformatf("wrap.count%0d", k), 64'(bus.count), 64'(1));
        end
        check("wrap.head19", 64'(bus.fu_pkt), 64'(mk_pkt(1'b1, ALU_1, 6'd19)));
        drive(1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 6'd0, 6'd0, 6'd0);
        step();
        check_state("wrap.end", 4'd0, 1'b0, 6'd0, 1'b0, 1'b1);

        // Reset in the middle of operation clears the sticky error too
        drive(1'b0, 1'b0, 1'b0, 3'b111, 3'b000, 6'd50, 6'd51, 6'd52);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'b111, 3'b000, 6'd53, 6'd54, 6'd55);
        step();
        check_state("rstmid.pre", 4'd6, 1'b1, 6'd50, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 6'd0, 6'd0, 6'd0);
        step();
        check_state("rstmid.post", 4'd0, 1'b0, 6'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 3'b100, 3'b000, 6'd0, 6'd0, 6'd60);
        step();
        check_state("rstmid.push", 4'd1, 1'b1, 6'd60, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
